// File: rtl/systolic_result_drain.sv
// Snapshots the systolic result vector on start and streams enabled columns in ascending order over valid/ready.
// Optional DRAIN_PARITY_EN adds out_parity, the registered XOR reduction of out_data.
module systolic_result_drain #(
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  localparam int CIDX_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [COLS*WORD_SIZE-1:0] results_in,
  input  logic [COLS-1:0]           col_en,
  output logic                      busy,
  output logic [WORD_SIZE-1:0]      out_data,
  output logic [CIDX_W-1:0]         out_col,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      done
`ifdef DRAIN_PARITY_EN
  ,
  output logic                      out_parity
`endif
);

  // Handshake: a word moves on a rising edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_data/out_col/out_last hold stable.
  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t                    state_q, state_d;
  logic [COLS*WORD_SIZE-1:0] buf_q, buf_d;
  logic [COLS-1:0]           mask_q, mask_d;
  logic [WORD_SIZE-1:0]      data_q, data_d;
  logic [CIDX_W-1:0]         col_q, col_d;
  logic                      last_q, last_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  // {found, index} of the lowest enabled column at or above lo.
  function automatic logic [CIDX_W:0] find_en(input logic [COLS-1:0] mask, input int lo);
    logic [CIDX_W:0] r;
    r = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) r = {1'b1, i[CIDX_W-1:0]};
    end
    return r;
  endfunction

  logic [CIDX_W:0] first_hit, first_after, next_hit, next_after;

  always_comb begin
    first_hit   = find_en(col_en, 0);
    first_after = find_en(col_en, int'(first_hit[CIDX_W-1:0]) + 1);
    next_hit    = find_en(mask_q, int'(col_q) + 1);
    next_after  = find_en(mask_q, int'(next_hit[CIDX_W-1:0]) + 1);
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    mask_d  = mask_q;
    data_d  = '0;
    col_d   = '0;
    last_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          buf_d  = results_in;
          mask_d = col_en;
          if (first_hit[CIDX_W]) begin
            state_d = STREAM;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            col_d   = first_hit[CIDX_W-1:0];
            data_d  = results_in[first_hit[CIDX_W-1:0]*WORD_SIZE +: WORD_SIZE];
            last_d  = ~first_after[CIDX_W];
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end
      STREAM: begin
        if (!out_ready) begin
          valid_d = 1'b1;
          busy_d  = 1'b1;
          col_d   = col_q;
          data_d  = data_q;
          last_d  = last_q;
        end else if (last_q) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          // Gaps in the mask are skipped within this single cycle.
          valid_d = 1'b1;
          busy_d  = 1'b1;
          col_d   = next_hit[CIDX_W-1:0];
          data_d  = buf_q[next_hit[CIDX_W-1:0]*WORD_SIZE +: WORD_SIZE];
          last_d  = ~next_after[CIDX_W];
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      col_q   <= col_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_data  = data_q;
  assign out_col   = col_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign done      = done_q;

`ifdef DRAIN_PARITY_EN
  logic parity_q;

  // data_d is zero whenever the next cycle carries no word, so parity follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= ^data_d;
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: directed timing checks plus randomized drains
// scored against a queue-based model of the enabled-column stream.
module tb_systolic_result_drain;
  localparam int COLS = 4;
  localparam int WS   = 16;
  localparam int W    = 1 + 2 + WS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [COLS*WS-1:0]   results_in = '0;
  logic [COLS-1:0]      col_en = '0;
  logic                 busy;
  logic [WS-1:0]        out_data;
  logic [1:0]           out_col;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 out_last;
  logic                 done;
`ifdef DRAIN_PARITY_EN
  logic                 out_parity;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;
  int done_exp = 0;
  int ready_mode = 0;
  logic [COLS*WS-1:0] base;
  logic [COLS*WS-1:0] rnd_data;
  logic [COLS-1:0]    rnd_mask;

  systolic_result_drain #(.COLS(COLS), .WORD_SIZE(WS)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .results_in(results_in),
    .col_en(col_en),
    .busy(busy),
    .out_data(out_data),
    .out_col(out_col),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .done(done)
`ifdef DRAIN_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each enabled column, ascending, one word; last = no higher enable.
  task automatic model_push(input logic [COLS*WS-1:0] res, input logic [COLS-1:0] en);
    for (int i = 0; i < COLS; i++) begin
      if (en[i]) begin
        logic lst;
        lst = ((en >> (i + 1)) == 0);
        exp_q.push_back({lst, 2'(i), res[i*WS +: WS]});
      end
    end
    done_exp++;
  endtask

  // Driver tasks
  task automatic issue_start(input logic [COLS*WS-1:0] res, input logic [COLS-1:0] en);
    results_in = res;
    col_en     = en;
    start      = 1'b1;
    model_push(res, en);
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic finish_drain(input string name);
    wait_done(name);
    cyc();
    chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
    chk({name, "_done_pending"}, done_exp, 32'd0);
  endtask

  always @(posedge clk) begin
    #2;
    if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=col%0d:%0h required=none", out_col, out_data);
        end else begin
          exp_word = exp_q.pop_front();
          chk("word", {13'b0, out_last, out_col, out_data}, {13'b0, exp_word});
`ifdef DRAIN_PARITY_EN
          chk("parity", 32'(out_parity), 32'(^exp_word[WS-1:0]));
`endif
        end
      end
`ifdef DRAIN_PARITY_EN
      if (!out_valid) chk("parity_idle", 32'(out_parity), 32'd0);
`endif
      if (done) begin
        chk("done_busy", 32'(busy), 32'd0);
        if (done_exp == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          done_exp--;
        end
      end
    end
  end

  initial begin
    base = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_col", 32'(out_col), 32'd0);
    rst = 1'b0;
    cyc();

    // Full mask, ready held high
    out_ready = 1'b1;
    issue_start(base, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      chk("full_valid", 32'(out_valid), 32'd1);
      chk("full_busy", 32'(busy), 32'd1);
      chk("full_col", 32'(out_col), 32'(k));
      chk("full_data", 32'(out_data), 32'(base[k*WS +: WS]));
      chk("full_last", 32'(out_last), 32'(k == 3));
      cyc();
    end
    chk("full_done_c5", 32'(done), 32'd1);
    chk("full_busy_c5", 32'(busy), 32'd0);
    chk("full_valid_c5", 32'(out_valid), 32'd0);
    finish_drain("full");

    // Sparse mask 1010
    issue_start(base, 4'b1010);
    chk("sparse_col1", 32'(out_col), 32'd1);
    chk("sparse_data1", 32'(out_data), 32'h2222);
    chk("sparse_last1", 32'(out_last), 32'd0);
    cyc();
    chk("sparse_col2", 32'(out_col), 32'd3);
    chk("sparse_data2", 32'(out_data), 32'h4444);
    chk("sparse_last2", 32'(out_last), 32'd1);
    cyc();
    chk("sparse_done", 32'(done), 32'd1);
    finish_drain("sparse");

    // Empty mask
    issue_start(base, 4'b0000);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    finish_drain("empty");
    chk("empty_valid_after", 32'(out_valid), 32'd0);

    // Backpressure on cycles 1..3
    out_ready = 1'b0;
    issue_start(base, 4'b1111);
    for (int k = 1; k <= 3; k++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h1111);
      chk("bp_col", 32'(out_col), 32'd0);
      chk("bp_last", 32'(out_last), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    finish_drain("bp");

    // Snapshot integrity and ignored start while streaming
    issue_start(base, 4'b1111);
    cyc();
    results_in = {COLS{16'hFFFF}};
    start = 1'b1;
    cyc();
    start = 1'b0;
    finish_drain("snap");
    for (int k = 0; k < 6; k++) begin
      chk("snap_idle_valid", 32'(out_valid), 32'd0);
      chk("snap_idle_busy", 32'(busy), 32'd0);
      cyc();
    end

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    issue_start(base, 4'b1111);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_col", 32'(out_col), 32'd0);
    exp_q.delete();
    done_exp = 0;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("arst_no_done", 32'(done), 32'd0);
      chk("arst_no_valid", 32'(out_valid), 32'd0);
    end

    // Post-reset drain with parity-sensitive words
    issue_start({16'h0000, 16'h0000, 16'h0003, 16'h0001}, 4'b0011);
    chk("par_data1", 32'(out_data), 32'h0001);
`ifdef DRAIN_PARITY_EN
    chk("par_bit1", 32'(out_parity), 32'd1);
`endif
    cyc();
    chk("par_data2", 32'(out_data), 32'h0003);
    chk("par_last2", 32'(out_last), 32'd1);
`ifdef DRAIN_PARITY_EN
    chk("par_bit2", 32'(out_parity), 32'd0);
`endif
    finish_drain("par");

    // Randomized drains
    for (int t = 0; t < 25; t++) begin
      rnd_data   = {$urandom, $urandom};
      rnd_mask   = 4'($urandom_range(0, 15));
      ready_mode = $urandom_range(0, 1);
      if (ready_mode == 0) out_ready = 1'b1;
      issue_start(rnd_data, rnd_mask);
      finish_drain("rand");
    end
    ready_mode = 0;
    out_ready  = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
